// File: rtl/pixel_array_controller_if.sv
// Row readout bus between the pixel array controller and the frame buffer.
//   read       : one-hot row select to the pixel array
//   row_index  : index of the row currently selected
//   row_valid  : selected row's data is stable
//   row_ready  : downstream accepts the row
// The controller connects through the master modport and the frame buffer
// side through the slave modport.
interface pixel_array_controller_if #(
  parameter int ROWS  = 4,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic [ROWS-1:0]  read;
  logic [ROW_W-1:0] row_index;
  logic             row_valid;
  logic             row_ready;

  modport master (
    output read,
    output row_index,
    output row_valid,
    input  row_ready
  );

  modport slave (
    input  read,
    input  row_index,
    input  row_valid,
    output row_ready
  );
endinterface

// File: rtl/pixel_array_controller.sv
// Global-shutter frame sequencer for the pixel array.
// One frame is ERASE, EXPOSE, a 256-step ramp conversion, then a
// row-by-row readout handed to the frame buffer over valid/ready.
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        single-cycle pulse, starts a frame from IDLE
//   continuous   restart automatically after the frame completes
//   expose_time  exposure length in cycles, 0 selects EXPOSE_CYCLES
//   erase        erase strobe to the array
//   expose       expose strobe to the array
//   convert      ramp-generator enable
//   counter      conversion code broadcast to the array
//   busy         high in every state except IDLE
//   frame_done   single-cycle pulse after the last row handshake
//   row_if       row select / row handshake bus (master side)
// All outputs come from registers only; no input reaches an output
// combinationally.
module pixel_array_controller #(
  parameter int ROWS          = 4,
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int READ_SETTLE   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [15:0] expose_time,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic [7:0]  counter,
  output logic        busy,
  output logic        frame_done,
  pixel_array_controller_if.master row_if
);

  localparam int               ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [15:0]      ERASE_LOAD  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0]      SETTLE_LOAD = 16'(READ_SETTLE);
  localparam logic             SETTLE_NONE = (READ_SETTLE == 0);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      timer, timer_nxt;       // shared down-counter for every phase
  logic [15:0]      exp_len, exp_len_nxt;   // exposure captured at frame start
  logic [7:0]       counter_nxt;
  logic [ROW_W-1:0] row_idx, row_idx_nxt;
  logic             row_valid_q, row_valid_nxt;

  function automatic logic [15:0] exposure_len(input logic [15:0] t);
    return (t == 16'd0) ? 16'(EXPOSE_CYCLES) : t;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      exp_len     <= '0;
      counter     <= '0;
      row_idx     <= '0;
      row_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      exp_len     <= exp_len_nxt;
      counter     <= counter_nxt;
      row_idx     <= row_idx_nxt;
      row_valid_q <= row_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    exp_len_nxt   = exp_len;
    counter_nxt   = counter;
    row_idx_nxt   = row_idx;
    row_valid_nxt = row_valid_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_ERASE;
          timer_nxt   = ERASE_LOAD;
          exp_len_nxt = exposure_len(expose_time);
          counter_nxt = 8'd0;
        end
      end

      // Timer is loaded with length-1 on entry, so the phase lasts
      // exactly "length" cycles and exits on the cycle it reads zero.
      S_ERASE: begin
        if (timer == 16'd0) begin
          state_nxt = S_EXPOSE;
          timer_nxt = exp_len - 16'd1;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      S_EXPOSE: begin
        if (timer == 16'd0) begin
          state_nxt   = S_CONVERT;
          counter_nxt = 8'd0;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end

      // The conversion code itself times this phase; it is left at 255
      // on exit and only cleared by the next frame start.
      S_CONVERT: begin
        if (counter == 8'd255) begin
          state_nxt     = S_READ;
          row_idx_nxt   = '0;
          timer_nxt     = SETTLE_LOAD;
          row_valid_nxt = SETTLE_NONE;
        end else begin
          counter_nxt = counter + 8'd1;
        end
      end

      S_READ: begin
        if (row_valid_q) begin
          if (row_if.row_ready) begin
            if (row_idx == LAST_ROW) begin
              state_nxt     = S_DONE;
              row_idx_nxt   = '0;
              row_valid_nxt = 1'b0;
            end else begin
              row_idx_nxt   = row_idx + ROW_W'(1);
              timer_nxt     = SETTLE_LOAD;
              row_valid_nxt = SETTLE_NONE;
            end
          end
        end else begin
          // Settle countdown; valid rises after READ_SETTLE cycles of select.
          if (timer == 16'd1) begin
            row_valid_nxt = 1'b1;
          end
          timer_nxt = timer - 16'd1;
        end
      end

      S_DONE: begin
        if (continuous) begin
          state_nxt   = S_ERASE;
          timer_nxt   = ERASE_LOAD;
          exp_len_nxt = exposure_len(expose_time);
          counter_nxt = 8'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the state register only.
  assign erase            = (state == S_ERASE);
  assign expose           = (state == S_EXPOSE);
  assign convert          = (state == S_CONVERT);
  assign busy             = (state != S_IDLE);
  assign frame_done       = (state == S_DONE);
  assign row_if.read      = (state == S_READ) ? (ROWS'(1) << row_idx) : '0;
  assign row_if.row_index = row_idx;
  assign row_if.row_valid = row_valid_q;

endmodule

// File: tb/tb_pixel_array_controller.sv
// Testbench for pixel_array_controller (ROWS=4, ERASE_CYCLES=5,
// EXPOSE_CYCLES=255, READ_SETTLE=2). Expected per-cycle outputs are
// generated from the frame rules as a queue of {inputs, outputs}.
module tb_pixel_array_controller;

  localparam int ROWS    = 4;
  localparam int ERASE_C = 5;
  localparam int EXPOSE_C = 255;
  localparam int SETTLE  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] expose_time = 16'd0;
  logic        erase, expose, convert, busy, frame_done;
  logic [7:0]  counter;

  pixel_array_controller_if #(.ROWS(ROWS)) row_if ();

  pixel_array_controller #(
    .ROWS(ROWS),
    .ERASE_CYCLES(ERASE_C),
    .EXPOSE_CYCLES(EXPOSE_C),
    .READ_SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .continuous(continuous),
    .expose_time(expose_time),
    .erase(erase),
    .expose(expose),
    .convert(convert),
    .counter(counter),
    .busy(busy),
    .frame_done(frame_done),
    .row_if(row_if)
  );

  always #5 clk = ~clk;

  // One cycle: inputs driven during the cycle, outputs expected in it.
  // Output layout: {erase, expose, convert, counter[7:0], read[3:0],
  //                 row_index[1:0], row_valid, busy, frame_done}
  typedef struct {
    logic        start;
    logic        cont;
    logic        rdy;
    logic [15:0] et;
    logic [19:0] o;
  } vec_t;

  typedef struct {
    logic [15:0] et;
    int          len;
  } xcase_t;

  vec_t   q[$];
  xcase_t xt[4];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  string  tag = "init";

  function automatic logic [19:0] pk(input logic er, input logic ex, input logic cv,
                                     input logic [7:0] cnt, input logic [3:0] rd,
                                     input logic [1:0] ix, input logic vl,
                                     input logic bs, input logic dn);
    return {er, ex, cv, cnt, rd, ix, vl, bs, dn};
  endfunction

  function automatic logic [19:0] sample();
    return pk(erase, expose, convert, counter, row_if.read, row_if.row_index,
              row_if.row_valid, busy, frame_done);
  endfunction

  function automatic logic rbit(input bit en, input logic dflt);
    return en ? 1'($urandom_range(0, 1)) : dflt;
  endfunction

  function automatic logic [15:0] r16(input bit en);
    return en ? 16'($urandom) : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [19:0] o, input logic st, input logic ct,
                      input logic rd, input logic [15:0] et);
    vec_t v;
    v.o = o; v.start = st; v.cont = ct; v.rdy = rd; v.et = et;
    q.push_back(v);
  endtask

  // n IDLE cycles; the last one carries the start pulse if requested.
  task automatic idle(input int n, input logic [7:0] cnt, input bit st_last,
                      input logic [15:0] et);
    for (int i = 0; i < n; i++)
      push(pk(0, 0, 0, cnt, 4'd0, 2'd0, 0, 0, 0),
           (i == n - 1) ? st_last : 1'b0, 1'b0, 1'b0,
           (i == n - 1) ? et : 16'd0);
  endtask

  // One frame from its first ERASE cycle through its DONE cycle.
  //   noise    : randomize inputs that must be ignored in each phase
  //   rdy_rand : random back-pressure; otherwise ready=1 except bp_len
  //              refused cycles on row bp_row
  //   cont_pre : continuous level up to readout; cont_done at readout/DONE
  task automatic model_frame(input int len, input bit noise, input bit rdy_rand,
                             input int bp_row, input int bp_len,
                             input bit cont_pre, input bit cont_done,
                             input logic [15:0] next_et);
    logic [3:0] oh;
    logic       rdy;
    int         waited;
    for (int i = 0; i < ERASE_C; i++)
      push(pk(1, 0, 0, 8'd0, 4'd0, 2'd0, 0, 1, 0),
           rbit(noise, 0), rbit(noise, cont_pre), rbit(noise, 0), r16(noise));
    for (int i = 0; i < len; i++)
      push(pk(0, 1, 0, 8'd0, 4'd0, 2'd0, 0, 1, 0),
           rbit(noise, 0), rbit(noise, cont_pre), rbit(noise, 0), r16(noise));
    for (int i = 0; i < 256; i++)
      push(pk(0, 0, 1, 8'(i), 4'd0, 2'd0, 0, 1, 0),
           rbit(noise, 0), rbit(noise, cont_pre), rbit(noise, 0), r16(noise));
    for (int r = 0; r < ROWS; r++) begin
      oh = 4'(1 << r);
      // Ready during settle is asserted (or random) and must not matter.
      for (int s = 0; s < SETTLE; s++)
        push(pk(0, 0, 0, 8'hFF, oh, 2'(r), 0, 1, 0),
             rbit(noise, 0), rbit(noise, cont_done), rbit(rdy_rand, 1), r16(noise));
      waited = 0;
      do begin
        if (rdy_rand) rdy = ($urandom_range(0, 2) != 0) || (waited >= 30);
        else          rdy = !((r == bp_row) && (waited < bp_len));
        push(pk(0, 0, 0, 8'hFF, oh, 2'(r), 1, 1, 0),
             rbit(noise, 0), rbit(noise, cont_done), rdy, r16(noise));
        waited++;
      end while (!rdy);
    end
    push(pk(0, 0, 0, 8'hFF, 4'd0, 2'd0, 0, 1, 1),
         rbit(noise, 0), cont_done, rbit(noise, 0), next_et);
  endtask

  // Called at posedge+1: compare, drive this cycle's inputs, advance.
  // Stops early after the CONVERT cycle showing counter == stop_cnt.
  task automatic run_q(input int stop_cnt, output bit stopped);
    vec_t v;
    stopped = 1'b0;
    while (q.size() > 0) begin
      v = q.pop_front();
      chk(tag, sample(), v.o);
      start = v.start;
      continuous = v.cont;
      row_if.row_ready = v.rdy;
      expose_time = v.et;
      if (stop_cnt >= 0 && v.o[17] && v.o[16:9] == 8'(stop_cnt)) begin
        stopped = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cyc %0d got running want finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit         stp;
    logic [15:0] et;
    row_if.row_ready = 1'b0;
    xt[0] = '{16'd0,   EXPOSE_C};
    xt[1] = '{16'd10,  10};
    xt[2] = '{16'd1,   1};
    xt[3] = '{16'd300, 300};

    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1 chk("reset_async", sample(), 20'd0);
    @(posedge clk); #1;
    chk("reset_hold", sample(), 20'd0);
    reset_n = 1'b1;

    // Exposure-length capture table, ready tied high.
    tag = "table";
    for (int k = 0; k < 4; k++) begin
      idle(2, (k == 0) ? 8'd0 : 8'hFF, 1'b1, xt[k].et);
      model_frame(xt[k].len, 0, 0, -1, 0, 0, 0, 16'd0);
      run_q(-1, stp);
    end

    // Exposure captured at start only; START pulses during EXPOSE ignored.
    tag = "capture";
    idle(1, 8'hFF, 1'b1, 16'd10);
    model_frame(10, 0, 0, -1, 0, 0, 0, 16'd0);
    for (int i = 1; i <= ERASE_C; i++) q[i].et = 16'd500;
    for (int i = ERASE_C + 1; i <= ERASE_C + 10; i++) q[i].start = 1'b1;
    run_q(-1, stp);

    // Back-pressure: 20 refused cycles on row 1.
    tag = "backpressure";
    idle(1, 8'hFF, 1'b1, 16'd3);
    model_frame(3, 0, 0, 1, 20, 0, 0, 16'd0);
    run_q(-1, stp);

    // Continuous for two frames, dropped during the second readout.
    tag = "continuous";
    idle(1, 8'hFF, 1'b1, 16'd4);
    model_frame(4, 0, 0, -1, 0, 1, 1, 16'd6);
    model_frame(6, 0, 0, -1, 0, 1, 0, 16'd0);
    idle(3, 8'hFF, 1'b0, 16'd0);
    run_q(-1, stp);

    // Randomized frames with ignored-input noise and random back-pressure.
    tag = "random";
    for (int f = 0; f < 3; f++) begin
      et = 16'($urandom_range(0, 30));
      idle($urandom_range(1, 3), 8'hFF, 1'b1, et);
      model_frame((et == 16'd0) ? EXPOSE_C : int'(et), 1, 1, -1, 0, 0, 0, 16'd0);
      run_q(-1, stp);
    end

    // Asynchronous reset mid-cycle during CONVERT at counter 100.
    tag = "midreset";
    idle(1, 8'hFF, 1'b1, 16'd2);
    model_frame(2, 0, 0, -1, 0, 0, 0, 16'd0);
    run_q(100, stp);
    checks++;
    if (!stp) begin
      errors++;
      $display("FAIL midreset_reach got stopped=%0d want 1", stp);
    end
    q.delete();
    #2 reset_n = 1'b0;
    #1 chk("midreset_async", sample(), 20'd0);
    @(posedge clk); #1;
    chk("midreset_hold", sample(), 20'd0);
    reset_n = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    tag = "after_reset";
    idle(3, 8'd0, 1'b0, 16'd0);
    idle(1, 8'd0, 1'b1, 16'd2);
    model_frame(2, 0, 0, -1, 0, 0, 0, 16'd0);
    idle(2, 8'hFF, 1'b0, 16'd0);
    run_q(-1, stp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
